mac_share_sched: RTL and testbench
==================================

# mac_share_sched

Round-robin scheduler sharing one fixed-latency arithmetic datapath (multiply/accumulate unit, external) among N_REQ requesters. Accepts operand pairs over valid/ready handshakes, issues at most one per cycle, tracks each issue's owner through a tag pipeline matched to the datapath latency, and routes each result back as a one-hot response pulse. Sits between requester blocks and the shared datapath instance.

## Interface
- W_DATA, 32, operand/result width
- N_REQ, 4, number of requesters (1..16)
- LAT, 3, datapath latency in advancing cycles (1..8)

- i_clk  input  1  clock, rising edge
- resetn  input  1  reset, asynchronous, active-low
- req_valid  input  N_REQ  per-requester operand valid
- req_ready  output  N_REQ  per-requester accept (one-hot or zero)
- req_a  input  N_REQ*W_DATA  operand A, requester i at [i*W_DATA +: W_DATA]
- req_b  input  N_REQ*W_DATA  operand B, same packing
- dp_valid  output  1  issue strobe to datapath
- dp_a, dp_b  output  W_DATA each  muxed operands of granted requester
- dp_ready  input  1  datapath advance enable; low = whole pipeline holds
- dp_result  input  W_DATA  result of the transaction in tag stage LAT-1
- rsp_valid  output  N_REQ  one-hot response pulse, registered
- rsp_data  output  W_DATA  response payload, registered
- busy  output  1  any tag stage valid or rsp_valid high

## Operation
- Arbitration: rotating priority pointer ptr (W_TAG bits). Winner = first i with req_valid[i], scanning ptr, ptr+1, ... modulo N_REQ.
- Handshake: req_ready[winner] = dp_ready; all others 0. Transfer when req_valid[i] & req_ready[i]. dp_valid = (any req_valid) & dp_ready. dp_a/dp_b = winner's operands (0 when no request).
- On transfer to i: ptr <= (i+1) mod N_REQ (wrap N_REQ-1 -> 0). No transfer: ptr holds.
- Requester may drop req_valid without transfer; no state retained for it.
- Tag pipeline: LAT stages of {valid, tag}. When dp_ready=1: stage0 <= {transfer, winner}; stage k <= stage k-1. When dp_ready=0: all stages hold.
- Response: when dp_ready=1, rsp_valid <= stage[LAT-1].valid ? onehot(stage[LAT-1].tag) : 0, rsp_data <= stage valid ? dp_result : rsp_data. When dp_ready=0: rsp_valid <= 0, rsp_data holds. No result is ever duplicated or dropped across stalls.
- Responses cannot be back-pressured; requesters must accept rsp_valid unconditionally.
- N_REQ=1: ptr constant 0; behaviour otherwise identical.

## Timing
- Reset values: ptr=0, all tag stages invalid, rsp_valid=0, rsp_data=0, busy=0. req_ready/dp_valid combinational; 0 while resetn low.
- Reset mid-operation: in-flight tags discarded, no responses emitted for them; first post-reset grant starts at requester 0.
- Issue latency: 0 cycles (combinational grant and dp_valid in request cycle).
- Issue-to-response: rsp_valid high in the cycle after LAT+1 advancing edges from the issue edge; with no stalls, issue in cycle t -> rsp_valid in cycle t+LAT+1, for exactly one cycle.
- Throughput: one issue and one response per advancing cycle; back-to-back issues give back-to-back responses in issue order.
- Fairness: continuously requesting requester waits at most N_REQ-1 transfers.

## Structure
- Shared package mac_share_pkg: W_TAG = max(1, clog2(N_REQ)), tag-stage struct/field widths, onehot-decode function.
- Sub-module rr_arbiter (req vector + ptr -> one-hot grant + encoded winner); tag pipeline, pointer update and response register stay in mac_share_sched.

## Test plan
- N_REQ=4, LAT=3, req_valid=4'b1111 held, dp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_valid one-hot 0001,0010,0100,1000 starting 4 cycles after first grant, rsp_data = dp_result of matching issue.
- ptr=2, only req_valid[1] high -> grant 1 immediately, ptr becomes 2; then req 0 and 3 high -> grant 3 then 0 (wrap).
- Issue at t, dp_ready low for cycles t+1..t+2 -> no grants, req_ready=0, rsp_valid stays 0; response appears at t+6, single pulse, correct data.
- Requester 2 raises then drops req_valid while dp_ready=0 -> no transfer, ptr unchanged, no response ever for 2.
- Three issues in flight, resetn asserted -> rsp_valid, busy, ptr cleared immediately; no response after release; next grant goes to lowest valid requester from 0.
- N_REQ=1, LAT=1, continuous requests -> req_ready follows dp_ready, rsp_valid=1 two cycles after first issue then every cycle.

Source files
------------

// File: rtl/mac_share_pkg.sv
// Shared types and helpers for the MAC-sharing scheduler: tag width
// derivation, the tag-pipeline stage record and a one-hot decoder.
package mac_share_pkg;

    // Largest supported requester count and the tag width that covers it
    localparam int MAX_REQ   = 16;
    localparam int MAX_TAG_W = 4;

    // Tag width for a given requester count, never narrower than one bit
    function automatic int tag_width(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

    // One slot of the owner-tracking pipeline; tag is zero-extended to the maximum width
    typedef struct packed {
        logic                 vld;
        logic [MAX_TAG_W-1:0] tag;
    } tag_stage_t;

    // Decode an owner tag into a one-hot requester vector
    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_TAG_W-1:0] tag);
        logic [MAX_REQ-1:0] r;
        r      = '0;
        r[tag] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mac_share_sched_rr_arbiter.sv
// Rotating-priority arbiter: picks the first asserted request at or after
// the priority pointer, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int W_TAG = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [W_TAG-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [W_TAG-1:0] o_winner,
    output logic             o_any
);

    logic [W_TAG:0]   w_sum;
    logic [W_TAG-1:0] w_idx;

    // Scan from the farthest offset down so the closest requester to ptr wins last
    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        o_any    = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (W_TAG + 1)'(k);
            if (w_sum >= (W_TAG + 1)'(N_REQ)) begin
                w_sum = w_sum - (W_TAG + 1)'(N_REQ);
            end
            w_idx = w_sum[W_TAG-1:0];
            if (i_req[w_idx]) begin
                o_any          = 1'b1;
                o_winner       = w_idx;
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_share_sched.sv
// Round-robin scheduler in front of one shared fixed-latency MAC datapath.
// Grants one requester per advancing cycle, carries the owner tag alongside
// the datapath, and returns each result as a registered one-hot pulse.
module mac_share_sched
    import mac_share_pkg::*;
#(
    parameter int W_DATA = 32,
    parameter int N_REQ  = 4,
    parameter int LAT    = 3
) (
    input  logic                    i_clk,
    input  logic                    resetn,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*W_DATA-1:0] req_a,
    input  logic [N_REQ*W_DATA-1:0] req_b,
    output logic                    dp_valid,
    output logic [W_DATA-1:0]       dp_a,
    output logic [W_DATA-1:0]       dp_b,
    input  logic                    dp_ready,
    input  logic [W_DATA-1:0]       dp_result,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [W_DATA-1:0]       rsp_data,
    output logic                    busy
);

    localparam int W_TAG = tag_width(N_REQ);

    logic [W_TAG-1:0]  r_ptr;
    logic [N_REQ-1:0]  w_grant;
    logic [W_TAG-1:0]  w_winner;
    logic              w_any;
    logic              w_adv;
    logic              w_xfer;
    tag_stage_t        r_tag_p [LAT];
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [W_DATA-1:0] r_rsp_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .W_TAG (W_TAG)
    ) u_arb (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Handshake is forced idle while reset is held so nothing issues during reset
    assign w_adv     = dp_ready & resetn;
    assign w_xfer    = w_any & w_adv;
    assign req_ready = w_grant & {N_REQ{w_adv}};
    assign dp_valid  = w_xfer;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    // Operand mux driven by the one-hot grant; zero when nobody requests
    always_comb begin
        dp_a = '0;
        dp_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                dp_a = req_a[i*W_DATA +: W_DATA];
                dp_b = req_b[i*W_DATA +: W_DATA];
            end
        end
    end

    // Priority pointer moves just past the requester that transferred
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_winner == W_TAG'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    // Owner tags shadow the datapath and freeze with it when dp_ready is low
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < LAT; k++) begin
                r_tag_p[k] <= '0;
            end
        end else if (dp_ready) begin
            r_tag_p[0] <= {w_xfer, MAX_TAG_W'(w_winner)};
            for (int k = 1; k < LAT; k++) begin
                r_tag_p[k] <= r_tag_p[k-1];
            end
        end
    end

    // Response register: one pulse per completed tag; a stall gives a zero
    // pulse while the last stage holds, so its result is sent exactly once
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else if (dp_ready) begin
            r_rsp_valid <= r_tag_p[LAT-1].vld ? N_REQ'(onehot(r_tag_p[LAT-1].tag)) : '0;
            if (r_tag_p[LAT-1].vld) begin
                r_rsp_data <= dp_result;
            end
        end else begin
            r_rsp_valid <= '0;
        end
    end

    // Busy while anything is in flight or a response is being presented
    always_comb begin
        busy = |r_rsp_valid;
        for (int k = 0; k < LAT; k++) begin
            busy = busy | r_tag_p[k].vld;
        end
    end

endmodule

// File: tb/tb_mac_share_sched.sv
// Bench for mac_share_sched: a 4-requester / latency-3 instance checked every
// cycle against a queue-based scoreboard, plus a 1-requester / latency-1
// instance exercised with a short directed sequence.
module tb_mac_share_sched;

    localparam int W = 32;
    localparam int N = 4;
    localparam int L = 3;

    logic clk = 1'b0;
    logic resetn;

    // Main instance signals
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           dp_valid;
    logic [W-1:0]   dp_a;
    logic [W-1:0]   dp_b;
    logic           dp_ready;
    logic [W-1:0]   dp_result;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;

    // Single-requester instance signals
    logic [0:0]     req_valid1;
    logic [0:0]     req_ready1;
    logic [W-1:0]   req_a1;
    logic [W-1:0]   req_b1;
    logic           dp_valid1;
    logic [W-1:0]   dp_a1;
    logic [W-1:0]   dp_b1;
    logic           dp_ready1;
    logic [W-1:0]   dp_result1;
    logic [0:0]     rsp_valid1;
    logic [W-1:0]   rsp_data1;
    logic           busy1;

    int n_checks = 0;
    int n_errors = 0;

    mac_share_sched #(.W_DATA(W), .N_REQ(N), .LAT(L)) dut (
        .i_clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_ready(dp_ready),
        .dp_result(dp_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    mac_share_sched #(.W_DATA(W), .N_REQ(1), .LAT(1)) dut1 (
        .i_clk(clk), .resetn(resetn),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_a(req_a1), .req_b(req_b1),
        .dp_valid(dp_valid1), .dp_a(dp_a1), .dp_b(dp_b1), .dp_ready(dp_ready1),
        .dp_result(dp_result1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Arithmetic the external datapath performs on an operand pair
    function automatic logic [W-1:0] mac_f(input logic [W-1:0] a, input logic [W-1:0] b);
        return a * b + 32'h0000_1001;
    endfunction

    // Stand-in for the external datapath: L-deep, advances only on dp_ready
    logic [W-1:0] dp_pipe [L];
    always_ff @(posedge clk) begin
        if (dp_ready) begin
            dp_pipe[0] <= dp_valid ? mac_f(dp_a, dp_b) : 32'h0BAD_0BAD;
            for (int k = 1; k < L; k++) dp_pipe[k] <= dp_pipe[k-1];
        end
    end
    assign dp_result = dp_pipe[L-1];

    logic [W-1:0] dp_r1;
    always_ff @(posedge clk) begin
        if (dp_ready1) dp_r1 <= mac_f(dp_a1, dp_b1);
    end
    assign dp_result1 = dp_r1;

    // Scoreboard: every accepted issue waits for L+1 advancing edges
    typedef struct {
        int           req;
        logic [W-1:0] data;
        int           cnt;
    } pend_t;
    pend_t        pend[$];
    int           m_ptr;
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle at the falling edge, then advance the reference model
    task automatic cycle();
        int           w;
        logic [N-1:0] exp_ready;
        logic         go;
        @(negedge clk);
        if (!resetn) begin
            pend.delete();
            m_ptr  = 0;
            exp_rv = '0;
            exp_rd = '0;
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (w < 0 && req_valid[i]) w = i;
        end
        go        = (w >= 0) && dp_ready && resetn;
        exp_ready = go ? (N'(1) << w) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("dp_valid", 64'(dp_valid), 64'(go));
        if (resetn) begin
            check("dp_a", 64'(dp_a), (w >= 0) ? 64'(req_a[w*W +: W]) : 64'd0);
            check("dp_b", 64'(dp_b), (w >= 0) ? 64'(req_b[w*W +: W]) : 64'd0);
        end
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("rsp_data", 64'(rsp_data), 64'(exp_rd));
        check("busy", 64'(busy), 64'((pend.size() > 0) || (exp_rv != '0)));
        if (resetn && dp_ready) begin
            exp_rv = '0;
            foreach (pend[j]) pend[j].cnt--;
            if (pend.size() > 0 && pend[0].cnt == 0) begin
                exp_rv = N'(1) << pend[0].req;
                exp_rd = pend[0].data;
                void'(pend.pop_front());
            end
            if (w >= 0) begin
                pend.push_back('{w, mac_f(req_a[w*W +: W], req_b[w*W +: W]), L});
                m_ptr = (w + 1) % N;
            end
        end else begin
            exp_rv = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy);
        req_valid = v;
        dp_ready  = rdy;
        req_a     = {$urandom, $urandom, $urandom, $urandom};
        req_b     = {$urandom, $urandom, $urandom, $urandom};
        cycle();
    endtask

    bit           pat1   [7] = '{1, 1, 1, 0, 1, 1, 1};
    bit           expv1  [7] = '{0, 0, 1, 1, 0, 1, 1};
    int           src1   [7] = '{-1, -1, 0, 1, 1, 2, 4};

    initial begin
        resetn     = 1'b0;
        req_valid  = '0;
        dp_ready   = 1'b1;
        req_a      = '0;
        req_b      = '0;
        req_valid1 = '0;
        dp_ready1  = 1'b1;
        req_a1     = '0;
        req_b1     = '0;
        m_ptr      = 0;
        exp_rv     = '0;
        exp_rd     = '0;
        @(posedge clk);
        #1;

        // Reset state: requests present but nothing granted, outputs cleared
        req_valid1 = 1'b1;
        drive(4'b1111, 1'b1);
        drive(4'b1111, 1'b1);
        check("rst_req_ready1", 64'(req_ready1), 64'd0);
        check("rst_rsp_valid1", 64'(rsp_valid1), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        req_valid1 = 1'b0;
        resetn     = 1'b1;

        // All four requesting back-to-back: grants 0,1,2,3,0,...
        for (int c = 0; c < 8; c++) drive(4'b1111, 1'b1);
        for (int c = 0; c < 6; c++) drive(4'b0000, 1'b1);

        // Pointer to 2 via a grant to 1, then lone request 1, then 3 and 0 with wrap
        drive(4'b0010, 1'b1);
        drive(4'b0010, 1'b1);
        drive(4'b1001, 1'b1);
        drive(4'b1001, 1'b1);
        for (int c = 0; c < 5; c++) drive(4'b0000, 1'b1);

        // Single issue followed by a two-cycle stall
        drive(4'b0100, 1'b1);
        drive(4'b0110, 1'b0);
        drive(4'b0110, 1'b0);
        for (int c = 0; c < 6; c++) drive(4'b0000, 1'b1);

        // Requester 2 raises then withdraws while stalled
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b0);
        for (int c = 0; c < 6; c++) drive(4'b0000, 1'b1);

        // Randomized traffic with random stalls
        for (int c = 0; c < 300; c++) begin
            drive(N'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
        end
        for (int c = 0; c < 8; c++) drive(4'b0000, 1'b1);

        // Reset with three issues in flight, then restart from requester 0
        for (int c = 0; c < 3; c++) drive(4'b1111, 1'b1);
        resetn = 1'b0;
        drive(4'b1010, 1'b1);
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) drive(4'b0000, 1'b1);
        drive(4'b1010, 1'b1);
        for (int c = 0; c < 6; c++) drive(4'b0000, 1'b1);

        // Single requester, latency 1: ready follows dp_ready, responses two cycles on
        req_valid1 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            dp_ready1 = pat1[c];
            req_a1    = W'(c + 1);
            req_b1    = W'(c + 2);
            @(negedge clk);
            check("n1_req_ready", 64'(req_ready1), 64'(pat1[c]));
            check("n1_rsp_valid", 64'(rsp_valid1), 64'(expv1[c]));
            if (src1[c] >= 0) begin
                check("n1_rsp_data", 64'(rsp_data1),
                      64'(mac_f(W'(src1[c] + 1), W'(src1[c] + 2))));
            end
            @(posedge clk);
            #1;
        end
        req_valid1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
